// File: rtl/qe_counter_if.sv
// qe_counter_if: bundle of encoder pins, control inputs and position outputs
// for the quadrature-encoder counter.
//   i, q, idx  : encoder channels A/B and index pulse (asynchronous pins)
//   idx_en     : 1 = rising edge of filtered idx zeroes the count
//   mode       : 00/11 = x4, 01 = x2, 10 = x1 decode
//   err_clr    : synchronous clear of the sticky error flag
//   count      : signed two's-complement position, W bits
//   dir        : direction of last counted step (0 = up, 1 = down)
//   step       : one-clock pulse on every counted step
//   err        : sticky illegal-transition flag
// master drives the pins/controls and reads results; slave is the counter.
interface qe_counter_if #(
    parameter int W = 16
) ();
    logic         i;
    logic         q;
    logic         idx;
    logic         idx_en;
    logic [1:0]   mode;
    logic         err_clr;
    logic [W-1:0] count;
    logic         dir;
    logic         step;
    logic         err;

    modport master (
        output i, q, idx, idx_en, mode, err_clr,
        input  count, dir, step, err
    );

    modport slave (
        input  i, q, idx, idx_en, mode, err_clr,
        output count, dir, step, err
    );
endinterface

// File: rtl/qe_counter.sv
// qe_counter: synchronously sampled quadrature-encoder position counter.
// Each of i, q and idx is passed through a 2-flop synchroniser and a glitch
// filter, then {fi,fq} transitions are decoded in x1/x2/x4 mode. The index
// rising edge (when enabled) zeroes the count; two-bit jumps set a sticky err.
// Ports:
//   clk : sampling clock, rising edge
//   clr : asynchronous active-high reset, clears all state
//   bus : qe_counter_if slave modport (pins, controls, count/dir/step/err)
// Handshake: none; step is a single-cycle strobe qualifying each count change.
module qe_counter #(
    parameter int W    = 16,
    parameter int FILT = 2
) (
    input  logic        clk,
    input  logic        clr,
    qe_counter_if.slave bus
);

    // channel order in the 3-bit vectors: [2] = idx, [1] = i, [0] = q
    logic [2:0]   r_s1;
    logic [2:0]   r_s2;
    logic [2:0]   r_filt;
    logic [3:0]   r_fcnt [3];
    logic [2:0]   w_filt;

    logic [1:0]   r_prev;
    logic         r_primed;
    logic         r_idx_prev;
    logic [W-1:0] r_count;
    logic         r_dir;
    logic         r_step;
    logic         r_err;

    logic [1:0]   w_cur;
    logic [1:0]   w_chg;
    logic         w_up;
    logic         w_dn;
    logic         w_en;
    logic         w_illegal;
    logic         w_cnt_up;
    logic         w_cnt_dn;
    logic         w_idx_rise;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {bus.idx, bus.i, bus.q};
            r_s2 <= r_s1;
        end
    end

    // r_fcnt counts consecutive clocks the synced value has disagreed with
    // r_filt. On the (FILT+1)-th such clock the filtered output already shows
    // the new value combinationally, so each unit of FILT costs exactly one
    // clock and FILT=0 degenerates to a plain wire from the synchroniser.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_filt <= '0;
            for (int c = 0; c < 3; c++) r_fcnt[c] <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (r_s2[c] != r_filt[c]) begin
                    if (r_fcnt[c] == 4'(FILT)) begin
                        r_filt[c] <= r_s2[c];
                        r_fcnt[c] <= '0;
                    end else begin
                        r_fcnt[c] <= r_fcnt[c] + 4'd1;
                    end
                end else begin
                    r_fcnt[c] <= '0;
                end
            end
        end
    end

    always_comb begin
        w_filt = r_filt;
        for (int c = 0; c < 3; c++) begin
            if ((r_s2[c] != r_filt[c]) && (r_fcnt[c] == 4'(FILT)))
                w_filt[c] = r_s2[c];
        end
    end

    assign w_cur = w_filt[1:0];
    assign w_chg = w_cur ^ r_prev;

    // Gray-code direction: up is 00->10->11->01->00
    always_comb begin
        w_up = 1'b0;
        w_dn = 1'b0;
        case ({r_prev, w_cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: w_up = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: w_dn = 1'b1;
            default: ;
        endcase
    end

    // x2 keeps only fi edges; x1 further keeps only the edges that touch 00
    // (leaving 00 going up, arriving at 00 going down).
    always_comb begin
        w_en = 1'b1;
        case (bus.mode)
            2'b01:   w_en = (w_chg == 2'b10);
            2'b10:   w_en = (w_chg == 2'b10) &&
                            (w_up ? (r_prev == 2'b00) : (w_cur == 2'b00));
            default: w_en = 1'b1;
        endcase
    end

    assign w_illegal  = r_primed && (w_chg == 2'b11);
    assign w_cnt_up   = r_primed && w_up && w_en;
    assign w_cnt_dn   = r_primed && w_dn && w_en;
    assign w_idx_rise = w_filt[2] && !r_idx_prev && bus.idx_en;

    // The first clock after clr only captures prev, so a pin level present at
    // release is never mistaken for a movement by the decoder.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_prev     <= 2'b00;
            r_primed   <= 1'b0;
            r_idx_prev <= 1'b0;
            r_count    <= '0;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_primed   <= 1'b1;
            r_prev     <= w_cur;
            r_idx_prev <= w_filt[2];
            r_step     <= w_cnt_up | w_cnt_dn;
            if (w_cnt_up | w_cnt_dn)
                r_dir <= w_cnt_dn;
            if (w_idx_rise)
                r_count <= '0;
            else if (w_cnt_up)
                r_count <= r_count + W'(1);
            else if (w_cnt_dn)
                r_count <= r_count - W'(1);
            // a fresh illegal transition wins over err_clr
            if (w_illegal)
                r_err <= 1'b1;
            else if (bus.err_clr)
                r_err <= 1'b0;
        end
    end

    assign bus.count = r_count;
    assign bus.dir   = r_dir;
    assign bus.step  = r_step;
    assign bus.err   = r_err;

endmodule
